// File: rtl/biquad_seq.sv
// biquad_seq: sequencer wrapped around an external multi-cycle biquad section.
// Paces accepted samples into the section at a fixed strobe spacing, tags which
// pipeline slots hold real samples, drains the pipeline on flush with zero
// samples, and swaps the coefficient bank only while the section is quiet.
module biquad_seq #(
    parameter int unsigned DATAWIDTH  = 16,
    parameter int unsigned COEFWIDTH  = 16,
    parameter int unsigned SPACING    = 4,
    parameter int unsigned PIPE_DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_addr,
    input  logic [COEFWIDTH-1:0] cfg_wdata,
    input  logic                 cfg_commit,
    output logic                 cfg_pending,
    output logic [DATAWIDTH-1:0] bq_x,
    output logic                 bq_valid,
    output logic [COEFWIDTH-1:0] bq_a11,
    output logic [COEFWIDTH-1:0] bq_a12,
    output logic [COEFWIDTH-1:0] bq_b10,
    output logic [COEFWIDTH-1:0] bq_b11,
    output logic [COEFWIDTH-1:0] bq_b12,
    input  logic [DATAWIDTH-1:0] bq_yout,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 flush_done,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SPACE = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Spacing counter reloads to SPACING-1 on every strobe (SPACING <= 15).
    localparam logic [3:0] SPACE_LOAD = 4'(SPACING - 1);
    // Number of zero strobes needed to push every real sample out (<= 8).
    localparam logic [3:0] FLUSH_LOAD = 4'(PIPE_DEPTH);

    // Unity gain in signed fractional format, the reset value of b10.
    localparam logic [COEFWIDTH-1:0] COEF_ONE = {1'b0, {(COEFWIDTH - 1){1'b1}}};
    localparam logic [COEFWIDTH-1:0] COEF_ZERO = '0;

    // Control state
    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            fcnt_q, fcnt_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [PIPE_DEPTH-1:0] tag_q, tag_d;

    // Datapath registers
    logic [DATAWIDTH-1:0]  bq_x_q;
    logic                  bq_valid_q;
    logic [DATAWIDTH-1:0]  out_data_q;
    logic                  out_valid_q;
    logic                  flush_done_q;

    // Coefficient banks
    logic                  pending_q;
    logic [COEFWIDTH-1:0]  sh_a11_q, sh_a12_q, sh_b10_q, sh_b11_q, sh_b12_q;
    logic [COEFWIDTH-1:0]  act_a11_q, act_a12_q, act_b10_q, act_b11_q, act_b12_q;

    // Decoded events
    logic accept;
    logic fl_strobe;
    logic fl_last;
    logic strobe;
    logic apply;

    // Handshake, strobe and commit-apply decode for the current cycle.
    always_comb begin
        // Counter must be zero too, so a sample after a flush keeps the spacing.
        in_ready  = !reset && (state_q == ST_IDLE) && (cnt_q == 4'd0) &&
                    !pending_q && !cfg_commit && !flush;
        accept    = in_valid && in_ready;
        fl_strobe = (state_q == ST_FLUSH) && (fcnt_q != 4'd0) && (cnt_q == 4'd0);
        fl_last   = (state_q == ST_FLUSH) && (fcnt_q == 4'd0);
        strobe    = accept || fl_strobe;
        apply     = pending_q && (state_q == ST_IDLE) && (cnt_q == 4'd0);
    end

    // Next-state logic for the IDLE / SPACE / FLUSH sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fcnt_d       = fcnt_q;
        flush_pend_d = flush_pend_q;
        tag_d        = tag_q;

        if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (strobe) begin
            cnt_d = SPACE_LOAD;
            // Real samples enter with tag 1, flush zeros with tag 0.
            tag_d = (tag_q << 1) | PIPE_DEPTH'(accept);
        end

        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end else if (accept && (SPACING > 1)) begin
                    state_d = ST_SPACE;
                end
            end
            ST_SPACE: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                // Last spacing cycle: counter is about to reach zero.
                if (cnt_q <= 4'd1) begin
                    if (flush_pend_q || flush) begin
                        state_d      = ST_FLUSH;
                        fcnt_d       = FLUSH_LOAD;
                        flush_pend_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                // Flush requests are ignored here; spacing tail continues in IDLE.
                if (fl_strobe) begin
                    fcnt_d = fcnt_q - 4'd1;
                end else if (fl_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            fcnt_q       <= 4'd0;
            flush_pend_q <= 1'b0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fcnt_q       <= fcnt_d;
            flush_pend_q <= flush_pend_d;
            tag_q        <= tag_d;
        end
    end

    // Filter strobe, sample hold and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            bq_x_q       <= '0;
            bq_valid_q   <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            bq_valid_q   <= strobe;
            flush_done_q <= fl_last;
            if (accept) begin
                bq_x_q <= in_data;
            end else if (fl_strobe) begin
                bq_x_q <= '0;
            end
            // Oldest tag reports whether this strobe's output is a real result.
            out_valid_q <= bq_valid_q && tag_q[PIPE_DEPTH-1];
            if (bq_valid_q && tag_q[PIPE_DEPTH-1]) begin
                out_data_q <= bq_yout;
            end
        end
    end

    // Shadow coefficient bank; writes are frozen while a commit is outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_a11_q <= COEF_ZERO;
            sh_a12_q <= COEF_ZERO;
            sh_b10_q <= COEF_ONE;
            sh_b11_q <= COEF_ZERO;
            sh_b12_q <= COEF_ZERO;
        end else if (cfg_we && !pending_q) begin
            case (cfg_addr)
                3'd0:    sh_a11_q <= cfg_wdata;
                3'd1:    sh_a12_q <= cfg_wdata;
                3'd2:    sh_b10_q <= cfg_wdata;
                3'd3:    sh_b11_q <= cfg_wdata;
                3'd4:    sh_b12_q <= cfg_wdata;
                default: ;
            endcase
        end
    end

    // Active bank and commit flag; the copy happens only with the section quiet.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b0;
            act_a11_q <= COEF_ZERO;
            act_a12_q <= COEF_ZERO;
            act_b10_q <= COEF_ONE;
            act_b11_q <= COEF_ZERO;
            act_b12_q <= COEF_ZERO;
        end else begin
            if (apply) begin
                act_a11_q <= sh_a11_q;
                act_a12_q <= sh_a12_q;
                act_b10_q <= sh_b10_q;
                act_b11_q <= sh_b11_q;
                act_b12_q <= sh_b12_q;
            end
            if (cfg_commit) begin
                pending_q <= 1'b1;
            end else if (apply) begin
                pending_q <= 1'b0;
            end
        end
    end

    // Output mapping.
    always_comb begin
        cfg_pending = pending_q;
        bq_x        = bq_x_q;
        bq_valid    = bq_valid_q;
        bq_a11      = act_a11_q;
        bq_a12      = act_a12_q;
        bq_b10      = act_b10_q;
        bq_b11      = act_b11_q;
        bq_b12      = act_b12_q;
        out_data    = out_data_q;
        out_valid   = out_valid_q;
        flush_done  = flush_done_q;
        busy        = (state_q != ST_IDLE) || (cnt_q != 4'd0);
    end

endmodule

// File: tb/tb_biquad_seq.sv
// Directed bench for biquad_seq: default instance (SPACING=4, PIPE_DEPTH=3)
// plus a SPACING=1 instance for back-to-back strobing.
module tb_biquad_seq;

    localparam int DW = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset;

    logic [DW-1:0] in_data, bq_x, bq_yout, out_data;
    logic          in_valid, in_ready, flush, cfg_we, cfg_commit, cfg_pending;
    logic [2:0]    cfg_addr;
    logic [CW-1:0] cfg_wdata, bq_a11, bq_a12, bq_b10, bq_b11, bq_b12;
    logic          bq_valid, out_valid, flush_done, busy;

    logic [DW-1:0] in_data1, bq_x1, bq_yout1, out_data1;
    logic          in_valid1, in_ready1, flush1, cfg_we1, cfg_commit1, cfg_pending1;
    logic [2:0]    cfg_addr1;
    logic [CW-1:0] cfg_wdata1, bq_a11_1, bq_a12_1, bq_b10_1, bq_b11_1, bq_b12_1;
    logic          bq_valid1, out_valid1, flush_done1, busy1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    biquad_seq #(
        .DATAWIDTH (DW),
        .COEFWIDTH (CW),
        .SPACING   (4),
        .PIPE_DEPTH(3)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_commit (cfg_commit),
        .cfg_pending(cfg_pending),
        .bq_x       (bq_x),
        .bq_valid   (bq_valid),
        .bq_a11     (bq_a11),
        .bq_a12     (bq_a12),
        .bq_b10     (bq_b10),
        .bq_b11     (bq_b11),
        .bq_b12     (bq_b12),
        .bq_yout    (bq_yout),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .flush_done (flush_done),
        .busy       (busy)
    );

    biquad_seq #(
        .DATAWIDTH (DW),
        .COEFWIDTH (CW),
        .SPACING   (1),
        .PIPE_DEPTH(3)
    ) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data1),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .flush      (flush1),
        .cfg_we     (cfg_we1),
        .cfg_addr   (cfg_addr1),
        .cfg_wdata  (cfg_wdata1),
        .cfg_commit (cfg_commit1),
        .cfg_pending(cfg_pending1),
        .bq_x       (bq_x1),
        .bq_valid   (bq_valid1),
        .bq_a11     (bq_a11_1),
        .bq_a12     (bq_a12_1),
        .bq_b10     (bq_b10_1),
        .bq_b11     (bq_b11_1),
        .bq_b12     (bq_b12_1),
        .bq_yout    (bq_yout1),
        .out_data   (out_data1),
        .out_valid  (out_valid1),
        .flush_done (flush_done1),
        .busy       (busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_data = '0; flush = 0; cfg_we = 0; cfg_addr = '0;
        cfg_wdata = '0; cfg_commit = 0; bq_yout = '0;
        in_valid1 = 0; in_data1 = '0; flush1 = 0; cfg_we1 = 0; cfg_addr1 = '0;
        cfg_wdata1 = '0; cfg_commit1 = 0; bq_yout1 = '0;
    endtask

    // Leaves the bench at cycle 0: first cycle with reset low.
    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        in_valid = 1; in_data = 16'h1234; in_valid1 = 1;
        tick();
        tick();
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else n_pass++;
        n_checks++; if (in_ready1 !== 1'b0) $display("FAIL rst_in_ready1 got %b want 0", in_ready1); else n_pass++;
        n_checks++; if (bq_valid !== 1'b0) $display("FAIL rst_bq_valid got %b want 0", bq_valid); else n_pass++;
        n_checks++; if (bq_x !== 16'h0000) $display("FAIL rst_bq_x got %h want 0000", bq_x); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 16'h0000) $display("FAIL rst_out_data got %h want 0000", out_data); else n_pass++;
        n_checks++; if (flush_done !== 1'b0) $display("FAIL rst_flush_done got %b want 0", flush_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (cfg_pending !== 1'b0) $display("FAIL rst_pending got %b want 0", cfg_pending); else n_pass++;
        n_checks++; if (bq_b10 !== 16'h7FFF) $display("FAIL rst_b10 got %h want 7fff", bq_b10); else n_pass++;
        n_checks++; if (bq_a11 !== 16'h0000) $display("FAIL rst_a11 got %h want 0000", bq_a11); else n_pass++;
        n_checks++; if (bq_a12 !== 16'h0000) $display("FAIL rst_a12 got %h want 0000", bq_a12); else n_pass++;
        n_checks++; if (bq_b11 !== 16'h0000) $display("FAIL rst_b11 got %h want 0000", bq_b11); else n_pass++;
        n_checks++; if (bq_b12 !== 16'h0000) $display("FAIL rst_b12 got %h want 0000", bq_b12); else n_pass++;
    endtask

    // Constant in_valid: handshakes at 0,4,8,12 -> strobes at 1,5,9,13.
    task automatic test_stream();
        logic exp_s;
        do_reset();
        in_valid = 1; in_data = 16'h1000; bq_yout = 16'h0ABC;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL stream_ready_c0 got %b want 1", in_ready); else n_pass++;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 11) bq_yout = 16'h0DEF;
            if (k == 16) in_valid = 0;
            #1;
            exp_s = (k % 4 == 1);
            n_checks++; if (bq_valid !== exp_s) $display("FAIL stream_bq_valid c%0d got %b want %b", k, bq_valid, exp_s); else n_pass++;
            if (exp_s) begin
                n_checks++; if (bq_x !== 16'h1000) $display("FAIL stream_bq_x c%0d got %h want 1000", k, bq_x); else n_pass++;
            end
            n_checks++; if (out_valid !== (k == 10 || k == 14)) $display("FAIL stream_out_valid c%0d got %b", k, out_valid); else n_pass++;
            n_checks++; if (in_ready !== (k % 4 == 0)) $display("FAIL stream_in_ready c%0d got %b want %b", k, in_ready, (k % 4 == 0)); else n_pass++;
            if (k == 10 || k == 12) begin
                n_checks++; if (out_data !== 16'h0ABC) $display("FAIL stream_out_data c%0d got %h want 0abc", k, out_data); else n_pass++;
            end
            if (k == 14) begin
                n_checks++; if (out_data !== 16'h0DEF) $display("FAIL stream_out_data c%0d got %h want 0def", k, out_data); else n_pass++;
            end
            if (k == 2) begin
                n_checks++; if (busy !== 1'b1) $display("FAIL stream_busy_space got %b want 1", busy); else n_pass++;
            end
        end
        n_checks++; if (busy !== 1'b0) $display("FAIL stream_busy_idle got %b want 0", busy); else n_pass++;
    endtask

    // Two samples (strobes 1,5), flush latched in SPACE -> zero strobes 9,13,17.
    task automatic test_flush();
        int n_ov;
        int n_fd;
        int n_st;
        logic exp_s;
        logic [DW-1:0] exp_x;
        n_ov = 0; n_fd = 0; n_st = 0;
        do_reset();
        in_valid = 1; in_data = 16'h0111; bq_yout = 16'h0AAA;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 1) in_data = 16'h0333;
            if (k == 5) in_valid = 0;
            if (k == 6) flush = 1;
            if (k == 7) flush = 0;
            if (k == 11) bq_yout = 16'h0BBB;
            if (k == 14) flush = 1;
            if (k == 15) flush = 0;
            #1;
            if (out_valid === 1'b1) n_ov++;
            if (flush_done === 1'b1) n_fd++;
            if (bq_valid === 1'b1) n_st++;
            exp_s = (k == 1 || k == 5 || k == 9 || k == 13 || k == 17);
            exp_x = (k == 1) ? 16'h0111 : (k == 5) ? 16'h0333 : 16'h0000;
            n_checks++; if (bq_valid !== exp_s) $display("FAIL flush_bq_valid c%0d got %b want %b", k, bq_valid, exp_s); else n_pass++;
            if (exp_s) begin
                n_checks++; if (bq_x !== exp_x) $display("FAIL flush_bq_x c%0d got %h want %h", k, bq_x, exp_x); else n_pass++;
            end
            n_checks++; if (out_valid !== (k == 10 || k == 14)) $display("FAIL flush_out_valid c%0d got %b", k, out_valid); else n_pass++;
            n_checks++; if (flush_done !== (k == 18)) $display("FAIL flush_done c%0d got %b", k, flush_done); else n_pass++;
            if (k == 10) begin
                n_checks++; if (out_data !== 16'h0AAA) $display("FAIL flush_out_data c10 got %h want 0aaa", out_data); else n_pass++;
            end
            if (k == 14) begin
                n_checks++; if (out_data !== 16'h0BBB) $display("FAIL flush_out_data c14 got %h want 0bbb", out_data); else n_pass++;
            end
            if (k == 8 || k == 18) begin
                n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready c%0d got %b want 0", k, in_ready); else n_pass++;
            end
            if (k == 19) begin
                n_checks++; if (busy !== 1'b1) $display("FAIL flush_busy_tail got %b want 1", busy); else n_pass++;
            end
            if (k == 20) begin
                n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready c20 got %b want 1", in_ready); else n_pass++;
                n_checks++; if (busy !== 1'b0) $display("FAIL flush_busy_end got %b want 0", busy); else n_pass++;
            end
        end
        n_checks++; if (n_ov != 2) $display("FAIL flush_out_count got %0d want 2", n_ov); else n_pass++;
        n_checks++; if (n_fd != 1) $display("FAIL flush_done_count got %0d want 1", n_fd); else n_pass++;
        n_checks++; if (n_st != 5) $display("FAIL flush_strobe_count got %0d want 5", n_st); else n_pass++;
    endtask

    // Strobe at 1 (SPACE 1..3); writes then commit at 3; applied end of 4.
    task automatic test_coef();
        do_reset();
        in_valid = 1; in_data = 16'h0100;
        for (int k = 1; k <= 13; k++) begin
            tick();
            case (k)
                1: begin in_valid = 0; cfg_we = 1; cfg_addr = 3'd2; cfg_wdata = 16'h4000; end
                2: begin cfg_addr = 3'd0; cfg_wdata = 16'h2000; end
                3: begin cfg_addr = 3'd6; cfg_wdata = 16'h1234; cfg_commit = 1; end
                4: begin cfg_commit = 0; cfg_addr = 3'd1; cfg_wdata = 16'h5555;
                         in_valid = 1; in_data = 16'h0200; end
                5: cfg_we = 0;
                6: begin in_valid = 0; cfg_commit = 1; end
                7: cfg_commit = 0;
                10: begin cfg_commit = 1; in_valid = 1; in_data = 16'h0300; end
                11: cfg_commit = 0;
                13: in_valid = 0;
                default: ;
            endcase
            #1;
            if (k == 3) begin
                n_checks++; if (bq_b10 !== 16'h7FFF) $display("FAIL coef_b10_shadow got %h want 7fff", bq_b10); else n_pass++;
            end
            if (k == 4) begin
                n_checks++; if (cfg_pending !== 1'b1) $display("FAIL coef_pending_c4 got %b want 1", cfg_pending); else n_pass++;
                n_checks++; if (in_ready !== 1'b0) $display("FAIL coef_in_ready_c4 got %b want 0", in_ready); else n_pass++;
                n_checks++; if (bq_b10 !== 16'h7FFF) $display("FAIL coef_b10_c4 got %h want 7fff", bq_b10); else n_pass++;
                n_checks++; if (bq_a11 !== 16'h0000) $display("FAIL coef_a11_c4 got %h want 0000", bq_a11); else n_pass++;
            end
            if (k == 5) begin
                n_checks++; if (cfg_pending !== 1'b0) $display("FAIL coef_pending_c5 got %b want 0", cfg_pending); else n_pass++;
                n_checks++; if (bq_b10 !== 16'h4000) $display("FAIL coef_b10_c5 got %h want 4000", bq_b10); else n_pass++;
                n_checks++; if (bq_a11 !== 16'h2000) $display("FAIL coef_a11_c5 got %h want 2000", bq_a11); else n_pass++;
                n_checks++; if (bq_a12 !== 16'h0000) $display("FAIL coef_a12_c5 got %h want 0000", bq_a12); else n_pass++;
                n_checks++; if (bq_b11 !== 16'h0000) $display("FAIL coef_b11_c5 got %h want 0000", bq_b11); else n_pass++;
                n_checks++; if (bq_b12 !== 16'h0000) $display("FAIL coef_b12_c5 got %h want 0000", bq_b12); else n_pass++;
                n_checks++; if (in_ready !== 1'b1) $display("FAIL coef_in_ready_c5 got %b want 1", in_ready); else n_pass++;
            end
            if (k == 6 || k == 13) begin
                n_checks++; if (bq_valid !== 1'b1) $display("FAIL coef_strobe c%0d got %b want 1", k, bq_valid); else n_pass++;
                n_checks++; if (bq_x !== ((k == 6) ? 16'h0200 : 16'h0300)) $display("FAIL coef_bq_x c%0d got %h", k, bq_x); else n_pass++;
            end
            if (k == 8 || k == 9) begin
                n_checks++; if (cfg_pending !== 1'b1) $display("FAIL coef_pending c%0d got %b want 1", k, cfg_pending); else n_pass++;
            end
            if (k == 10) begin
                n_checks++; if (cfg_pending !== 1'b0) $display("FAIL coef_pending_c10 got %b want 0", cfg_pending); else n_pass++;
                n_checks++; if (bq_a12 !== 16'h0000) $display("FAIL coef_a12_locked got %h want 0000", bq_a12); else n_pass++;
                n_checks++; if (bq_b10 !== 16'h4000) $display("FAIL coef_b10_c10 got %h want 4000", bq_b10); else n_pass++;
                n_checks++; if (in_ready !== 1'b0) $display("FAIL coef_commit_prio got %b want 0", in_ready); else n_pass++;
            end
            if (k == 11) begin
                n_checks++; if (in_ready !== 1'b0) $display("FAIL coef_in_ready_c11 got %b want 0", in_ready); else n_pass++;
            end
            if (k == 12) begin
                n_checks++; if (in_ready !== 1'b1) $display("FAIL coef_in_ready_c12 got %b want 1", in_ready); else n_pass++;
            end
        end
    endtask

    // Flush from IDLE strobes at 2; reset during cycle 2; sample at 3 strobes at 4.
    task automatic test_reset_flush();
        do_reset();
        flush = 1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) flush = 0;
            if (k == 2) reset = 1;
            if (k == 3) begin reset = 0; in_valid = 1; in_data = 16'h0555; end
            if (k == 4) in_valid = 0;
            #1;
            if (k == 2) begin
                n_checks++; if (bq_valid !== 1'b1) $display("FAIL rf_flush_strobe got %b want 1", bq_valid); else n_pass++;
                n_checks++; if (busy !== 1'b1) $display("FAIL rf_busy got %b want 1", busy); else n_pass++;
            end
            if (k == 3) begin
                n_checks++; if (bq_valid !== 1'b0) $display("FAIL rf_bq_valid got %b want 0", bq_valid); else n_pass++;
                n_checks++; if (busy !== 1'b0) $display("FAIL rf_busy_after got %b want 0", busy); else n_pass++;
                n_checks++; if (bq_x !== 16'h0000) $display("FAIL rf_bq_x got %h want 0000", bq_x); else n_pass++;
                n_checks++; if (out_valid !== 1'b0) $display("FAIL rf_out_valid got %b want 0", out_valid); else n_pass++;
                n_checks++; if (cfg_pending !== 1'b0) $display("FAIL rf_pending got %b want 0", cfg_pending); else n_pass++;
            end
            if (k >= 3) begin
                n_checks++; if (flush_done !== 1'b0) $display("FAIL rf_flush_done c%0d got %b want 0", k, flush_done); else n_pass++;
                n_checks++; if (bq_valid !== (k == 4)) $display("FAIL rf_strobe c%0d got %b", k, bq_valid); else n_pass++;
            end
            if (k == 4) begin
                n_checks++; if (bq_x !== 16'h0555) $display("FAIL rf_sample got %h want 0555", bq_x); else n_pass++;
            end
        end
    endtask

    // SPACING=1: handshakes 0..4 -> strobes 1..5; outputs after strobes 3,4,5.
    task automatic test_back_to_back();
        logic [DW-1:0] exp_x;
        do_reset();
        in_valid1 = 1; in_data1 = 16'h0010; bq_yout1 = 16'h0777;
        #1;
        n_checks++; if (in_ready1 !== 1'b1) $display("FAIL b2b_in_ready c0 got %b want 1", in_ready1); else n_pass++;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k <= 4) in_data1 = DW'(16 + k);
            if (k == 5) in_valid1 = 0;
            #1;
            exp_x = DW'(16 + k - 1);
            if (k <= 4) begin
                n_checks++; if (in_ready1 !== 1'b1) $display("FAIL b2b_in_ready c%0d got %b want 1", k, in_ready1); else n_pass++;
            end
            n_checks++; if (bq_valid1 !== (k <= 5)) $display("FAIL b2b_bq_valid c%0d got %b", k, bq_valid1); else n_pass++;
            if (k <= 5) begin
                n_checks++; if (bq_x1 !== exp_x) $display("FAIL b2b_bq_x c%0d got %h want %h", k, bq_x1, exp_x); else n_pass++;
            end
            n_checks++; if (out_valid1 !== (k >= 4 && k <= 6)) $display("FAIL b2b_out_valid c%0d got %b", k, out_valid1); else n_pass++;
            if (k == 4) begin
                n_checks++; if (out_data1 !== 16'h0777) $display("FAIL b2b_out_data got %h want 0777", out_data1); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_flush();
        test_coef();
        test_reset_flush();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/biquad_seq.md
BIQUAD_SEQ -- requirements
Module: biquad_seq

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 16: sample width, signed fractional two's complement.
REQ-002 SHALL have parameter COEFWIDTH, default 16: coefficient width, signed fractional.
REQ-003 SHALL have parameter SPACING, default 4, legal range 1..15: minimum clocks between filter strobes, equal to the multiplier cycle count.
REQ-004 SHALL have parameter PIPE_DEPTH, default 3, legal range 1..8: strobes from a sample entering the filter to its result on the filter output.
REQ-005 SHALL have these ports:
- clk  in  1  clock; one clock domain; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  DATAWIDTH  input sample.
- in_valid  in  1  input sample offered.
- in_ready  out  1  block accepts in_data this cycle.
- flush  in  1  single-cycle request to drain the pipeline.
- cfg_we  in  1  shadow coefficient write strobe.
- cfg_addr  in  3  coefficient select: 0=a11, 1=a12, 2=b10, 3=b11, 4=b12; 5..7 ignored.
- cfg_wdata  in  COEFWIDTH  coefficient write data.
- cfg_commit  in  1  request to copy shadow coefficients to active.
- cfg_pending  out  1  commit requested, not yet applied.
- bq_x  out  DATAWIDTH  sample to the filter section.
- bq_valid  out  1  filter strobe.
- bq_a11, bq_a12, bq_b10, bq_b11, bq_b12  out  COEFWIDTH each  active coefficients.
- bq_yout  in  DATAWIDTH  filter section output.
- out_data  out  DATAWIDTH  filtered result.
- out_valid  out  1  out_data valid; one-cycle pulse; no backpressure.
- flush_done  out  1  one-cycle pulse when a flush completes.
- busy  out  1  high whenever the state is not IDLE or the spacing counter is nonzero.

Function
REQ-006 SHALL implement the FSM states IDLE, SPACE and FLUSH, with the transitions given in REQ-007 to REQ-010.
REQ-007 SHALL assert in_ready only when all of these hold: state IDLE, no cfg_pending, no flush this cycle.
REQ-008 SHALL, on a handshake (in_valid and in_ready high) in cycle t:
- in cycle t+1, register bq_x = in_data and pulse bq_valid for one cycle;
- shift a real-sample tag of 1 into the tag register;
- move to SPACE.
REQ-009 SHALL hold bq_x constant between strobes.
REQ-010 SHALL, in SPACE, count SPACING-1 cycles after the strobe cycle and then return to IDLE or FLUSH.
- Strobes are therefore at least SPACING clocks apart.
- With SPACING=1, SPACE is skipped and back-to-back handshakes strobe every cycle.
REQ-011 SHALL keep a tag shift register of PIPE_DEPTH bits, shifted on every strobe, with the new bit entering at index 0.
REQ-012 SHALL, in the cycle after each strobe, when tag[PIPE_DEPTH-1]=1:
- pulse out_valid;
- set out_data = bq_yout.
out_data SHALL hold its value otherwise.
REQ-013 SHALL handle flush as follows:
- A flush seen in IDLE enters FLUSH immediately.
- A flush seen in SPACE is latched and FLUSH is entered when spacing expires.
- FLUSH issues exactly PIPE_DEPTH strobes with bq_x=0 and tag 0, spaced SPACING clocks apart.
- flush_done pulses in the cycle after the last flush strobe, and the state returns to IDLE.
- A flush during FLUSH is ignored.
REQ-014 SHALL emit, during a flush, the pending real results normally via out_valid; flush strobes themselves SHALL never produce out_valid.
REQ-015 SHALL handle coefficients as follows:
- cfg_we writes the shadow register selected by cfg_addr, only while cfg_pending=0.
- cfg_we while cfg_pending=1 is ignored.
- cfg_commit sets cfg_pending.
REQ-016 SHALL apply a pending commit as follows:
- It is applied on the first cycle with state IDLE and the spacing counter at 0.
- All five active registers are copied in the same edge, and cfg_pending clears on that edge.
- Active coefficients never change on a strobe cycle or during SPACE.
REQ-017 SHALL give cfg_commit priority over an in_valid arriving in the same cycle: in_ready stays low until the commit is applied.
REQ-018 SHALL have no arithmetic on samples; widths pass through unchanged.

Reset
REQ-019 SHALL, while reset is high at a rising clk edge, return the block to its reset state in that cycle, including mid-flush or mid-spacing:
- state IDLE, spacing counter 0, tags all 0, latched flush cleared;
- bq_x=0, bq_valid=0, out_data=0, out_valid=0, flush_done=0, cfg_pending=0, in_ready=0 during reset, busy=0;
- active and shadow coefficients: b10=2^(COEFWIDTH-1)-1 (0x7FFF), a11=a12=b11=b12=0.
REQ-020 SHALL hold in_ready low while reset is high, and it may rise in the first cycle after reset deasserts.

Verification
REQ-021 Reset release, constant in_valid=1, in_data=0x1000: bq_valid pulses every 4 clocks; first out_valid follows the third strobe by 1 cycle; out_data = bq_yout.
REQ-022 SPACING=1: in_valid held high for 5 cycles -> 5 consecutive bq_valid pulses; in_ready is never low during the run.
REQ-023 Two samples accepted, then flush -> 3 zero strobes 4 clocks apart; exactly 2 out_valid pulses in total; flush_done 1 cycle after the third zero strobe; the flush is latched if it arrives during SPACE.
REQ-024 Write b10=0x4000, a11=0x2000, commit during SPACE:
- cfg_pending stays high until spacing expires, then clears;
- bq_b10=0x4000 and bq_a11=0x2000 change in that same cycle;
- a write with cfg_addr=6 has no effect.
REQ-025 Reset asserted 2 clocks into a flush -> all outputs at reset values next cycle; no flush_done; the next accepted sample is strobed normally.
